// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, key value
// constants and the row priority helper used by the frame encoder.
package keypad_pkg;

   typedef enum logic [1:0] {
      S_SCAN   = 2'd0,
      S_EVAL   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   localparam logic [4:0] KEY_NONE       = 5'h00;
   localparam int         KEY_HELD_BIT   = 4;

   // Game key codes as seen by the graphics/game controller
   localparam logic [4:0] KEY_RIGHT      = 5'h11;
   localparam logic [4:0] KEY_LEFT       = 5'h13;
   localparam logic [4:0] KEY_START_MASK = 5'h10;

   // Index of the lowest-numbered active-low row; only meaningful when at
   // least one row is low.
   function automatic logic [1:0] lowest_row(input logic [3:0] rows_n);
      logic [1:0] idx;
      if (!rows_n[0]) begin
         idx = 2'd0;
      end else if (!rows_n[1]) begin
         idx = 2'd1;
      end else if (!rows_n[2]) begin
         idx = 2'd2;
      end else begin
         idx = 2'd3;
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: counts identical consecutive frame results and
// reports when the candidate value has been stable for DEBOUNCE_CNT frames.
// Outputs reflect the update of the current frame so the caller can act in
// the same (EVAL) cycle.
module keypad_debounce #(
   parameter int DEBOUNCE_CNT = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [4:0] raw_i,
   input  logic       frame_done_i,
   output logic       stable_o,
   output logic [4:0] stable_val_o
);
   import keypad_pkg::*;

   localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CNT);

   if ((DEBOUNCE_CNT < 1) || (DEBOUNCE_CNT > 255)) begin : g_bad_debounce
      $error("DEBOUNCE_CNT must be in 1..255");
   end

   logic [7:0] cnt_q, cnt_d;
   logic [4:0] last_q, last_d;

   // Compare the new frame result against the candidate; saturate the count
   always_comb begin
      cnt_d  = cnt_q;
      last_d = last_q;
      if (frame_done_i) begin
         if (raw_i == last_q) begin
            if (cnt_q < CNT_MAX) begin
               cnt_d = cnt_q + 8'd1;
            end else begin
               cnt_d = cnt_q;
            end
         end else begin
            cnt_d  = 8'd1;
            last_d = raw_i;
         end
      end else begin
         cnt_d  = cnt_q;
         last_d = last_q;
      end
   end

   // Candidate value and its stability count
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= 8'd0;
         last_q <= KEY_NONE;
      end else begin
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

   assign stable_o     = frame_done_i && (cnt_d == CNT_MAX);
   assign stable_val_o = last_d;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame debounce, press pulse generation and
// optional auto-repeat (enabled by defining KEYPAD_REPEAT_EN).
module keypad_scan #(
   parameter int SCAN_DIV     = 25000,
   parameter int DEBOUNCE_CNT = 8,
   parameter int REPEAT_DELAY = 40,
   parameter int REPEAT_RATE  = 10
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] key_row_i,
   output logic [3:0] key_col_o,
   output logic [4:0] key_o,
   output logic [4:0] key_pulse_o
);
   import keypad_pkg::*;

   localparam int             DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   if (SCAN_DIV < 4) begin : g_bad_div
      $error("SCAN_DIV must be >= 4");
   end
   if ((REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_bad_repeat
      $error("REPEAT_DELAY and REPEAT_RATE must be >= 1");
   end

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       col_q, col_d;
   logic [3:0]       col_drv_q;
   logic [4:0]       acc_q, acc_d;
   logic [4:0]       raw_q, raw_d;
   logic [4:0]       key_q, key_d;
   logic [4:0]       pulse_q, pulse_d;
   logic [3:0]       row_meta_q, row_sync_q;
   logic [4:0]       merged_s;
   logic             stable_s;
   logic [4:0]       stable_val_s;
`ifdef KEYPAD_REPEAT_EN
   logic [7:0]       rep_cnt_q, rep_cnt_d;
   logic             rep_first_q, rep_first_d;
   logic [7:0]       rep_limit_s;
`endif

   // Two-flop synchroniser for the asynchronous row inputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
      end else begin
         row_meta_q <= key_row_i;
         row_sync_q <= row_meta_q;
      end
   end

   // Fold this column's lowest pressed row into the frame's best code
   always_comb begin
      logic [4:0] base;
      logic [3:0] code;
      base = (col_q == 2'd0) ? KEY_NONE : acc_q;
      code = {lowest_row(row_sync_q), col_q};
      if ((row_sync_q != 4'hF) && (!base[KEY_HELD_BIT] || (code < base[3:0]))) begin
         merged_s = {1'b1, code};
      end else begin
         merged_s = base;
      end
   end

   keypad_debounce #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) u_debounce (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .raw_i        (raw_q),
      .frame_done_i (state_q == S_EVAL),
      .stable_o     (stable_s),
      .stable_val_o (stable_val_s)
   );

`ifdef KEYPAD_REPEAT_EN
   assign rep_limit_s = rep_first_q ? 8'(REPEAT_DELAY) : 8'(REPEAT_RATE);
`endif

   // Next-state: column scan, frame evaluation, key commit and pulse
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      col_d   = col_q;
      acc_d   = acc_q;
      raw_d   = raw_q;
      key_d   = key_q;
      pulse_d = KEY_NONE;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
`endif
      case (state_q)
         S_SCAN: begin
            if (div_q == DIV_LAST) begin
               div_d = {DIV_W{1'b0}};
               col_d = col_q + 2'd1;
               acc_d = merged_s;
               if (col_q == 2'd3) begin
                  raw_d   = merged_s;
                  state_d = S_EVAL;
               end else begin
                  state_d = S_SCAN;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_EVAL: begin
            if (stable_s && (stable_val_s != key_q)) begin
               state_d = S_COMMIT;
`ifdef KEYPAD_REPEAT_EN
               rep_cnt_d   = 8'd0;
               rep_first_d = 1'b1;
`endif
            end else begin
               state_d = S_SCAN;
`ifdef KEYPAD_REPEAT_EN
               // Count held frames only while the candidate agrees with key
               if (key_q[KEY_HELD_BIT] && (stable_val_s == key_q)) begin
                  if ((rep_cnt_q + 8'd1) >= rep_limit_s) begin
                     pulse_d     = key_q;
                     rep_cnt_d   = 8'd0;
                     rep_first_d = 1'b0;
                  end else begin
                     rep_cnt_d = rep_cnt_q + 8'd1;
                  end
               end else begin
                  rep_cnt_d   = 8'd0;
                  rep_first_d = 1'b1;
               end
`endif
            end
         end
         S_COMMIT: begin
            key_d = stable_val_s;
            if (stable_val_s[KEY_HELD_BIT]) begin
               pulse_d = stable_val_s;
            end else begin
               pulse_d = KEY_NONE;
            end
            state_d = S_SCAN;
         end
         default: begin
            state_d = S_SCAN;
         end
      endcase
   end

   // State and datapath registers; reset aborts any partial frame
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_SCAN;
         div_q     <= {DIV_W{1'b0}};
         col_q     <= 2'd0;
         col_drv_q <= 4'b1110;
         acc_q     <= KEY_NONE;
         raw_q     <= KEY_NONE;
         key_q     <= KEY_NONE;
         pulse_q   <= KEY_NONE;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt_q   <= 8'd0;
         rep_first_q <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         col_q     <= col_d;
         col_drv_q <= ~(4'b0001 << col_d);
         acc_q     <= acc_d;
         raw_q     <= raw_d;
         key_q     <= key_d;
         pulse_q   <= pulse_d;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
`endif
      end
   end

   assign key_col_o   = col_drv_q;
   assign key_o       = key_q;
   assign key_pulse_o = pulse_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: stimulus pushes expected key/pulse
// events, a negedge monitor pops and compares whenever key changes or a
// pulse appears. Define KEYPAD_REPEAT_EN to also expect auto-repeat pulses.
module tb_keypad_scan;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 3;
   localparam int REPEAT_DELAY = 4;
   localparam int REPEAT_RATE  = 2;

   logic       clk = 1'b0;
   logic       rst_i;
   logic [3:0] key_row_i;
   logic [3:0] key_col_o;
   logic [4:0] key_o;
   logic [4:0] key_pulse_o;
   logic [15:0] pressed;

   typedef struct packed {
      logic       pulse;
      logic [4:0] val;
   } ev_t;

   ev_t        exp_q[$];
   int         checks   = 0;
   int         failures = 0;
   logic       mon_en   = 1'b0;
   logic [4:0] prev_key = 5'h00;

   always #5 clk = ~clk;

   keypad_scan #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .key_row_i   (key_row_i),
      .key_col_o   (key_col_o),
      .key_o       (key_o),
      .key_pulse_o (key_pulse_o)
   );

   // Keypad matrix: a pressed key pulls its row low while its column is driven
   always_comb begin
      key_row_i = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && (key_col_o[c] === 1'b0)) begin
               key_row_i[r] = 1'b0;
            end
         end
      end
   end

   task automatic expect_ev(input logic p, input logic [4:0] v);
      ev_t e;
      e.pulse = p;
      e.val   = v;
      exp_q.push_back(e);
   endtask

   task automatic check_ev(input logic p, input logic [4:0] v);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_%s actual=%h required=none at %0t",
                  p ? "pulse" : "key", v, $time);
      end else begin
         e = exp_q.pop_front();
         if ((e.pulse !== p) || (e.val !== v)) begin
            failures++;
            $display("FAIL event actual=%s:%h required=%s:%h at %0t",
                     p ? "pulse" : "key", v, e.pulse ? "pulse" : "key", e.val, $time);
         end
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every key change and every nonzero pulse is one event
   always @(negedge clk) begin
      if (mon_en) begin
         if (key_o !== prev_key) begin
            check_ev(1'b0, key_o);
            prev_key = key_o;
         end
         if (key_pulse_o !== 5'h00) begin
            check_ev(1'b1, key_pulse_o);
         end
      end
   end

   task automatic wait_empty(input string name, input int budget);
      int n = 0;
      while ((exp_q.size() != 0) && (n < budget)) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s actual=%0d_pending required=0_pending_within_%0d_clks",
                  name, exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   task automatic wait_frames(input int n);
      int cnt = 0;
      int guard = 0;
      logic [3:0] prev_col = key_col_o;
      while ((cnt < n) && (guard < n * 40)) begin
         @(negedge clk);
         guard++;
         if ((prev_col == 4'b0111) && (key_col_o == 4'b1110)) cnt++;
         prev_col = key_col_o;
      end
      if (cnt < n) begin
         checks++;
         failures++;
         $display("FAIL frame_timeout actual=%0d required=%0d", cnt, n);
      end
   endtask

   task automatic wait_col(input logic [3:0] col);
      int guard = 0;
      @(negedge clk);
      while ((key_col_o !== col) && (guard < 40)) begin
         @(negedge clk);
         guard++;
      end
      if (key_col_o !== col) begin
         checks++;
         failures++;
         $display("FAIL col_timeout actual=%b required=%b", key_col_o, col);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] one;
      logic [3:0] exp_col;
      int idx;
      one     = 4'b0001;
      pressed = 16'h0000;
      rst_i   = 1'b1;

      // 1: reset values, then column rotation every SCAN_DIV clks
      @(posedge clk);
      @(negedge clk);
      chk("rst_key", {3'd0, key_o}, 8'h00);
      chk("rst_pulse", {3'd0, key_pulse_o}, 8'h00);
      chk("rst_col", {4'd0, key_col_o}, 8'h0E);
      @(posedge clk);
      #1 rst_i = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         @(negedge clk);
         idx     = (k < 16) ? (k / 4) : 0;
         exp_col = ~(one << idx);
         chk("col_rotate", {4'd0, key_col_o}, {4'd0, exp_col});
      end
      prev_key = 5'h00;
      mon_en   = 1'b1;

      // 2: single press of code 5, latency bounded by 4 frames plus sync
      pressed[5] = 1'b1;
      expect_ev(1'b0, 5'h15);
      expect_ev(1'b1, 5'h15);
      wait_empty("press_latency", 77);
      wait_frames(3);
      pressed[5] = 1'b0;
      expect_ev(1'b0, 5'h00);
      wait_empty("release5", 80);

      // 3: key toggled once per frame never settles
      wait_frames(1);
      for (int i = 0; i < 6; i++) begin
         wait_col(4'b1101);
         pressed[4] = (i % 2 == 0);
         wait_frames(1);
      end
      wait_frames(4);
      chk("bounce_key", {3'd0, key_o}, 8'h00);

      // 4: two keys -> lowest code; drop it -> direct change with one pulse
      pressed[3] = 1'b1;
      pressed[9] = 1'b1;
      expect_ev(1'b0, 5'h13);
      expect_ev(1'b1, 5'h13);
      wait_empty("multi_13", 80);
      pressed[3] = 1'b0;
      expect_ev(1'b0, 5'h19);
      expect_ev(1'b1, 5'h19);
      wait_empty("change_19", 80);

      // 5: release without pulse, then reset mid-frame while held
      pressed[9] = 1'b0;
      expect_ev(1'b0, 5'h00);
      wait_empty("release9", 80);
      pressed[9] = 1'b1;
      expect_ev(1'b0, 5'h19);
      expect_ev(1'b1, 5'h19);
      wait_empty("press9", 80);
      wait_col(4'b1011);
      expect_ev(1'b0, 5'h00);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      chk("midrst_key", {3'd0, key_o}, 8'h00);
      chk("midrst_pulse", {3'd0, key_pulse_o}, 8'h00);
      chk("midrst_col", {4'd0, key_col_o}, 8'h0E);
      expect_ev(1'b0, 5'h19);
      expect_ev(1'b1, 5'h19);
      wait_empty("redetect", 80);
      pressed[9] = 1'b0;
      expect_ev(1'b0, 5'h00);
      wait_empty("release9b", 80);

      // 6: hold code 1; repeat pulses only when the feature is built in
      pressed[1] = 1'b1;
      expect_ev(1'b0, 5'h11);
      expect_ev(1'b1, 5'h11);
      wait_empty("press1", 80);
`ifdef KEYPAD_REPEAT_EN
      for (int i = 0; i < 4; i++) expect_ev(1'b1, 5'h11);
      wait_empty("repeat1", 12 * 18);
`else
      wait_frames(12);
`endif
      pressed[1] = 1'b0;
      expect_ev(1'b0, 5'h00);
      wait_empty("release1", 80);
      wait_frames(2);
      chk("queue_drained", 8'(exp_q.size()), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
